gate3_test_seq: RTL
===================

GATE3_TEST_SEQ -- requirements
Module: gate3_test_seq

Interface
REQ-001 Parameter SETTLE, default 2: extra cycles each vector is held before O is sampled (range 0..15).
REQ-002 Parameter EXPECT_TT, default 8'h80: expected truth table, where bit n is the expected O for vector n (8'h80 = 3-input AND).
REQ-003 Port CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port RST_N  in  1  reset; synchronous, active-low.
REQ-005 Port START  in  1  single-cycle request to begin a test run.
REQ-006 Port ABORT  in  1  terminates a run in progress.
REQ-007 Port O  in  1  output of the gate under test.
REQ-008 Port DRV  out  3  stimulus to the gate under test: DRV[0]->I0, DRV[1]->I1, DRV[2]->I2.
REQ-009 Port BUSY  out  1  high while a run is in progress.
REQ-010 Port DONE  out  1  one-cycle pulse when a run completes.
REQ-011 Port PASS  out  1  high when the last completed run had zero mismatches.
REQ-012 Port ERR_CNT  out  4  number of mismatching vectors in the current or last run (0..8).
REQ-013 Port FAIL_VLD  out  1  high when at least one mismatch has been recorded.
REQ-014 Port FAIL_VEC  out  3  first mismatching vector; valid only while FAIL_VLD is high.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, DRIVE, DONE_ST, ABORT_ST.
REQ-016 IDLE with START=1 and ABORT=0 SHALL go to DRIVE with vector=0 and settle count=0, and clear ERR_CNT, FAIL_VLD, FAIL_VEC and PASS.
REQ-017 In DRIVE, DRV SHALL equal the current vector; each vector is held for SETTLE+1 cycles.
REQ-018 In the last hold cycle (count==SETTLE), O SHALL be compared with EXPECT_TT[vector].
REQ-019 On a mismatch, ERR_CNT SHALL increment; if FAIL_VLD=0, FAIL_VEC<=vector and FAIL_VLD<=1.
REQ-020 After the compare, if vector<7 the block SHALL increment the vector, reset the count and stay in DRIVE; if vector==7 it SHALL go to DONE_ST.
REQ-021 DONE_ST SHALL last one cycle with DONE=1 and BUSY=0, then go to IDLE.
REQ-022 PASS SHALL be set to (ERR_CNT==0, including the final compare) on entry to DONE_ST and hold until the next accepted START.
REQ-023 Latency: if START is sampled at edge k, DRIVE spans cycles k+1 .. k+8*(SETTLE+1), and DONE is high in cycle k+8*(SETTLE+1)+1.
REQ-024 BUSY SHALL be 1 exactly in DRIVE.
REQ-025 DRV SHALL be 3'b000 in every state other than DRIVE.
REQ-026 START SHALL be ignored in every state other than IDLE; a re-START during a run has no effect.
REQ-027 ABORT=1 in DRIVE SHALL go to ABORT_ST for one cycle, then to IDLE, with no DONE pulse and PASS=0.
REQ-028 After an abort, ERR_CNT, FAIL_VLD and FAIL_VEC SHALL retain their partial values.
REQ-029 START and ABORT high in the same IDLE cycle: ABORT SHALL win and the block SHALL stay in IDLE.
REQ-030 ABORT in DONE_ST SHALL be ignored, and DONE still pulses.
REQ-031 ERR_CNT SHALL never exceed 8 and SHALL not wrap.

Reset
REQ-032 RST_N=0 sampled at a rising edge SHALL force IDLE, DRV=000, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VLD=0, FAIL_VEC=000 on that edge, overriding START and ABORT.
REQ-033 RST_N=0 mid-run SHALL discard the run without a DONE pulse.
REQ-034 The first START is accepted on the first edge with RST_N=1.

Verification
REQ-035 Good AND3 model, SETTLE=2, START at edge 0 -> DRV steps 000..111 every 3 cycles; DONE in cycle 25; PASS=1; ERR_CNT=0; FAIL_VLD=0.
REQ-036 O stuck at 1, default parameters -> ERR_CNT=7, FAIL_VEC=000, FAIL_VLD=1, PASS=0.
REQ-037 O stuck at 0 -> ERR_CNT=1, FAIL_VEC=111, PASS=0.
REQ-038 ABORT in cycle 10 of a run -> ABORT_ST in cycle 11, IDLE in cycle 12; DONE never pulses; DRV=000 from cycle 11.
REQ-039 START pulsed again mid-run, plus START and ABORT together in IDLE -> no restart, no state change; DONE timing identical to REQ-035.
REQ-040 RST_N low in cycle 7 of a failing run -> all outputs at reset values at the next edge; a fresh run then completes normally.

Source files
------------

// File: rtl/gate3_test_seq.sv
`default_nettype none
// ============================================================================
// Module      : gate3_test_seq
// Description : Sequences all eight input vectors through a 3-input gate and
//               checks its output against an expected truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module gate3_test_seq #(
  parameter int unsigned SETTLE    = 2,
  parameter logic [7:0]  EXPECT_TT = 8'h80
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       ABORT,
  input  logic       O,
  output logic [2:0] DRV,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic       FAIL_VLD,
  output logic [2:0] FAIL_VEC
);

  localparam logic [3:0] c_settle  = SETTLE[3:0];
  localparam logic [3:0] c_err_max = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRIVE    = 2'd1,
    S_DONE_ST  = 2'd2,
    S_ABORT_ST = 2'd3
  } state_t;

  state_t     state_q;
  logic [2:0] vec_q;
  logic [3:0] cnt_q;
  logic [2:0] drv_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_q;
  logic       fvld_q;
  logic [2:0] fvec_q;

  logic       w_mismatch;
  logic [3:0] err_d;

  assign w_mismatch = (O != EXPECT_TT[vec_q]);
  // Saturating count of mismatches including the compare happening this cycle.
  assign err_d = (w_mismatch && (err_q != c_err_max)) ? err_q + 4'd1 : err_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 4'd0;
      drv_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      fvld_q  <= 1'b0;
      fvec_q  <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START && !ABORT) begin
            state_q <= S_DRIVE;
            vec_q   <= 3'd0;
            cnt_q   <= 4'd0;
            drv_q   <= 3'd0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            fvld_q  <= 1'b0;
            fvec_q  <= 3'd0;
          end
        end
        S_DRIVE: begin
          if (ABORT) begin
            state_q <= S_ABORT_ST;
            drv_q   <= 3'd0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (cnt_q == c_settle) begin
            err_q <= err_d;
            if (w_mismatch && !fvld_q) begin
              fvld_q <= 1'b1;
              fvec_q <= vec_q;
            end
            if (vec_q == 3'd7) begin
              state_q <= S_DONE_ST;
              drv_q   <= 3'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == 4'd0);
            end else begin
              vec_q <= vec_q + 3'd1;
              drv_q <= vec_q + 3'd1;
              cnt_q <= 4'd0;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DONE_ST: begin
          state_q <= S_IDLE;
        end
        S_ABORT_ST: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          drv_q   <= 3'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DRV      = drv_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VLD = fvld_q;
  assign FAIL_VEC = fvec_q;

endmodule
`default_nettype wire
